// File: rtl/axi4_pkg.sv
// Flit layout shared by the AXI4-stream flit serializer and deserializer.
// Metadata sits in the top bits, MSB first: {valid, tail, dest, vc}.
`ifndef DEST_BITS
`define DEST_BITS 2
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH (64 + 2 + `DEST_BITS + `VC_BITS)
`endif

package axi4_pkg;

    localparam int unsigned FLIT_DEST_BITS        = `DEST_BITS;
    localparam int unsigned FLIT_VC_BITS          = `VC_BITS;
    localparam int unsigned AXI4S_FLIT_DATA_WIDTH = 256;
    localparam int unsigned FLIT_META_W           = 2 + FLIT_DEST_BITS + FLIT_VC_BITS;

    // Field offsets within the metadata slice.
    localparam int unsigned META_VC_LSB    = 0;
    localparam int unsigned META_DEST_LSB  = FLIT_VC_BITS;
    localparam int unsigned META_TAIL_POS  = META_DEST_LSB + FLIT_DEST_BITS;
    localparam int unsigned META_VALID_POS = META_TAIL_POS + 1;

endpackage

// File: rtl/flit_vc_deserializer_pkg.sv
// Types and helpers for the per-VC flit deserializer.
package flit_vc_deserializer_pkg;

    typedef enum logic [0:0] {StFill, StFull} lane_state_e;

    function automatic int unsigned calc_len(input int unsigned out_data,
                                             input int unsigned in_data);
        return (out_data + in_data - 1) / in_data;
    endfunction

    function automatic int unsigned min_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flit_vc_deserializer_lane.sv
// One reassembly lane (flit_vc_lane): collects LEN narrow beats into a wide flit.
// Optional dest consistency check under FLIT_VC_DESER_ERRCHK_EN.
module flit_vc_lane
    import axi4_pkg::*, flit_vc_deserializer_pkg::*;
#(
    parameter int unsigned IN_DATA = 64,
    parameter int unsigned LEN     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_i,
    input  logic [IN_DATA-1:0]       beat_data_i,
    input  logic [FLIT_META_W-1:0]   beat_meta_i,
    input  logic                     drain_i,
`ifdef FLIT_VC_DESER_ERRCHK_EN
    output logic                     err_o,
`endif
    output logic                     full_o,
    output logic [LEN*IN_DATA-1:0]   data_o,
    output logic [FLIT_META_W-1:0]   meta_o
);

    localparam int unsigned CntW = min_w(LEN);

    lane_state_e             state_q;
    logic [CntW-1:0]         cnt_q;
    logic [LEN*IN_DATA-1:0]  data_q;
    logic [FLIT_META_W-1:0]  meta_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StFill;
            cnt_q   <= '0;
            data_q  <= '0;
            meta_q  <= '0;
        end else if (state_q == StFill) begin
            if (wr_i) begin
                data_q[cnt_q*IN_DATA +: IN_DATA] <= beat_data_i;
                if (cnt_q == CntW'(LEN - 1)) begin
                    state_q <= StFull;
                    cnt_q   <= '0;
                    meta_q  <= beat_meta_i;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end else if (drain_i) begin
            state_q <= StFill;
            data_q  <= '0;
            meta_q  <= '0;
        end
    end

    assign full_o = (state_q == StFull);
    assign data_o = data_q;
    assign meta_o = meta_q;

`ifdef FLIT_VC_DESER_ERRCHK_EN
    logic [FLIT_DEST_BITS-1:0] first_dest_q;
    logic [FLIT_DEST_BITS-1:0] beat_dest;
    logic                      err_q;

    assign beat_dest = beat_meta_i[META_DEST_LSB +: FLIT_DEST_BITS];

    // Every later beat of a packet must carry the dest seen on its first beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            first_dest_q <= '0;
            err_q        <= 1'b0;
        end else if (wr_i && state_q == StFill) begin
            if (cnt_q == '0) begin
                first_dest_q <= beat_dest;
            end else if (beat_dest != first_dest_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: rtl/flit_vc_deserializer.sv
// Reassembles VC-interleaved narrow flits into wide flits, one lane per VC, with
// round-robin output arbitration. FLIT_VC_DESER_ERRCHK_EN adds err_dest_mismatch.
module flit_vc_deserializer
    import axi4_pkg::*, flit_vc_deserializer_pkg::*;
#(
    parameter int unsigned IN_FLIT_WIDTH  = `FLIT_WIDTH,
    parameter int unsigned OUT_FLIT_WIDTH = AXI4S_FLIT_DATA_WIDTH + 2 + `DEST_BITS + `VC_BITS,
    parameter int unsigned NUM_VCS        = 2
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [IN_FLIT_WIDTH-1:0]  in_flit,
    input  logic                      in_flit_valid,
    output logic                      in_flit_ready,
    output logic [OUT_FLIT_WIDTH-1:0] out_flit,
    output logic                      out_flit_valid,
`ifdef FLIT_VC_DESER_ERRCHK_EN
    output logic                      err_dest_mismatch,
`endif
    input  logic                      out_flit_ready
);

    localparam int unsigned InData  = IN_FLIT_WIDTH - FLIT_META_W;
    localparam int unsigned OutData = OUT_FLIT_WIDTH - FLIT_META_W;
    localparam int unsigned Len     = calc_len(OutData, InData);
    localparam int unsigned GntW    = min_w(NUM_VCS);

    logic [FLIT_VC_BITS-1:0] in_vc;
    logic [NUM_VCS-1:0]      lane_wr, lane_drain, lane_full;
    logic [Len*InData-1:0]   lane_data [NUM_VCS];
    logic [FLIT_META_W-1:0]  lane_meta [NUM_VCS];
    logic [GntW-1:0]         rr_q, lock_vc_q, arb_vc, gnt_vc;
    logic                    lock_q, arb_found, out_fire;
    int unsigned             idx;

    assign in_vc = in_flit[InData + META_VC_LSB +: FLIT_VC_BITS];

    always_comb begin
        in_flit_ready = 1'b0;
        for (int i = 0; i < NUM_VCS; i++) begin
            if (in_vc == FLIT_VC_BITS'(i) && !lane_full[i]) begin
                in_flit_ready = RST_N;
            end
        end
    end

    // rr_q holds the highest-priority VC for the next decision.
    always_comb begin
        arb_vc    = rr_q;
        arb_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_VCS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_VCS) begin
                idx = idx - NUM_VCS;
            end
            if (!arb_found && lane_full[GntW'(idx)]) begin
                arb_found = 1'b1;
                arb_vc    = GntW'(idx);
            end
        end
    end

    assign gnt_vc         = lock_q ? lock_vc_q : arb_vc;
    assign out_flit_valid = RST_N && (lock_q || arb_found);
    assign out_fire       = out_flit_valid && out_flit_ready;
    assign out_flit       = RST_N ? {lane_meta[gnt_vc], lane_data[gnt_vc][OutData-1:0]} : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
        end else begin
            lock_q    <= out_flit_valid && !out_flit_ready;
            lock_vc_q <= gnt_vc;
            if (out_fire) begin
                rr_q <= (gnt_vc == GntW'(NUM_VCS - 1)) ? '0 : gnt_vc + 1'b1;
            end
        end
    end

`ifdef FLIT_VC_DESER_ERRCHK_EN
    logic [NUM_VCS-1:0] lane_err;
    assign err_dest_mismatch = |lane_err;
`endif

    for (genvar g = 0; g < NUM_VCS; g++) begin : g_lane
        assign lane_wr[g]    = in_flit_valid && in_flit_ready && (in_vc == FLIT_VC_BITS'(g));
        assign lane_drain[g] = out_fire && (gnt_vc == GntW'(g));

        flit_vc_lane #(
            .IN_DATA (InData),
            .LEN     (Len)
        ) u_lane (
            .clk_i       (CLK),
            .rst_ni      (RST_N),
            .wr_i        (lane_wr[g]),
            .beat_data_i (in_flit[InData-1:0]),
            .beat_meta_i (in_flit[IN_FLIT_WIDTH-1 -: FLIT_META_W]),
            .drain_i     (lane_drain[g]),
`ifdef FLIT_VC_DESER_ERRCHK_EN
            .err_o       (lane_err[g]),
`endif
            .full_o      (lane_full[g]),
            .data_o      (lane_data[g]),
            .meta_o      (lane_meta[g])
        );
    end

endmodule

// File: tb/tb_flit_vc_deserializer.sv
// Directed bench for flit_vc_deserializer (DEST_BITS=2, VC_BITS=1, 64->256 data, 2 VCs).
// Set FLIT_VC_DESER_ERRCHK_EN to also exercise err_dest_mismatch.
module tb_flit_vc_deserializer;

    localparam int unsigned InW  = 69;
    localparam int unsigned OutW = 261;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [InW-1:0]  in_flit = '0;
    logic            in_flit_valid = 1'b0;
    logic            in_flit_ready;
    logic [OutW-1:0] out_flit;
    logic            out_flit_valid;
    logic            out_flit_ready = 1'b0;
`ifdef FLIT_VC_DESER_ERRCHK_EN
    logic            err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    flit_vc_deserializer #(
        .IN_FLIT_WIDTH  (InW),
        .OUT_FLIT_WIDTH (OutW),
        .NUM_VCS        (2)
    ) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .in_flit           (in_flit),
        .in_flit_valid     (in_flit_valid),
        .in_flit_ready     (in_flit_ready),
        .out_flit          (out_flit),
        .out_flit_valid    (out_flit_valid),
`ifdef FLIT_VC_DESER_ERRCHK_EN
        .err_dest_mismatch (err),
`endif
        .out_flit_ready    (out_flit_ready)
    );

    typedef struct {
        logic [InW-1:0]  flit;
        logic            vld;
        logic            ordy;
        logic            e_irdy;
        logic            e_ov;
        logic [OutW-1:0] e_flit;
    } vec_t;

    vec_t vecs[16];
    logic [OutW-1:0] exp_a, exp_b;
    logic [OutW-1:0] exp_rr[2];

    function automatic logic [InW-1:0] beat(input logic vc, input logic [1:0] dest,
                                            input logic tail, input logic [63:0] d);
        return {1'b1, tail, dest, vc, d};
    endfunction

    function automatic logic [OutW-1:0] ofl(input logic vc, input logic [1:0] dest,
                                            input logic tail, input logic [63:0] d0,
                                            input logic [63:0] d1, input logic [63:0] d2,
                                            input logic [63:0] d3);
        return {1'b1, tail, dest, vc, d3, d2, d1, d0};
    endfunction

    function automatic logic [OutW-1:0] pkt_flit(input logic vc, input logic [1:0] dest,
                                                 input logic [63:0] base);
        return ofl(vc, dest, 1'b1, base, base + 64'd1, base + 64'd2, base + 64'd3);
    endfunction

    task automatic chk(input string name, input logic [OutW-1:0] act,
                       input logic [OutW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [InW-1:0] f, input string name);
        @(negedge CLK);
        in_flit       = f;
        in_flit_valid = 1'b1;
        #1;
        chk(name, OutW'(in_flit_ready), OutW'(1));
        @(posedge CLK);
        #1;
        in_flit_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic vc, input logic [1:0] dest, input logic [63:0] base);
        for (int k = 0; k < 4; k++) begin
            send_beat(beat(vc, dest, (k == 3), base + 64'(k)), $sformatf("pkt_vc%0d_b%0d", vc, k));
        end
    endtask

    initial begin
        // Single packet on VC0, then a fully interleaved VC0/VC1 pair.
        vecs[0]  = '{beat(1'b0, 2'd2, 1'b0, 64'h1), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[1]  = '{beat(1'b0, 2'd2, 1'b0, 64'h2), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[2]  = '{beat(1'b0, 2'd2, 1'b0, 64'h3), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[3]  = '{beat(1'b0, 2'd2, 1'b1, 64'h4), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[4]  = '{beat(1'b0, 2'd0, 1'b0, 64'h0), 1'b0, 1'b1, 1'b0, 1'b1,
                     ofl(1'b0, 2'd2, 1'b1, 64'h1, 64'h2, 64'h3, 64'h4)};
        vecs[5]  = '{beat(1'b0, 2'd0, 1'b0, 64'h0), 1'b0, 1'b1, 1'b1, 1'b0, '0};
        vecs[6]  = '{beat(1'b0, 2'd1, 1'b0, 64'h10), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[7]  = '{beat(1'b1, 2'd3, 1'b0, 64'h20), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[8]  = '{beat(1'b0, 2'd1, 1'b0, 64'h11), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[9]  = '{beat(1'b1, 2'd3, 1'b0, 64'h21), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[10] = '{beat(1'b0, 2'd1, 1'b0, 64'h12), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[11] = '{beat(1'b1, 2'd3, 1'b0, 64'h22), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[12] = '{beat(1'b0, 2'd1, 1'b1, 64'h13), 1'b1, 1'b1, 1'b1, 1'b0, '0};
        vecs[13] = '{beat(1'b1, 2'd3, 1'b1, 64'h23), 1'b1, 1'b1, 1'b1, 1'b1,
                     ofl(1'b0, 2'd1, 1'b1, 64'h10, 64'h11, 64'h12, 64'h13)};
        vecs[14] = '{beat(1'b1, 2'd0, 1'b0, 64'h0), 1'b0, 1'b1, 1'b0, 1'b1,
                     ofl(1'b1, 2'd3, 1'b1, 64'h20, 64'h21, 64'h22, 64'h23)};
        vecs[15] = '{beat(1'b1, 2'd0, 1'b0, 64'h0), 1'b0, 1'b1, 1'b1, 1'b0, '0};

        // Reset values.
        in_flit = beat(1'b0, 2'd0, 1'b0, 64'h0);
        @(negedge CLK);
        #1;
        chk("rst_in_rdy", OutW'(in_flit_ready), '0);
        chk("rst_out_valid", OutW'(out_flit_valid), '0);
        chk("rst_out_flit", out_flit, '0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            in_flit        = vecs[i].flit;
            in_flit_valid  = vecs[i].vld;
            out_flit_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_rdy", i), OutW'(in_flit_ready), OutW'(vecs[i].e_irdy));
            chk($sformatf("vec%0d_out_valid", i), OutW'(out_flit_valid), OutW'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_out_flit", i), out_flit, vecs[i].e_flit);
            end
        end
        in_flit_valid  = 1'b0;
        out_flit_ready = 1'b0;

        // Backpressure: both lanes full, output held on VC0, no beats accepted.
        for (int k = 0; k < 4; k++) begin
            send_beat(beat(1'b0, 2'd2, (k == 3), 64'hA0 + 64'(k)), $sformatf("bp_vc0_b%0d", k));
            send_beat(beat(1'b1, 2'd1, (k == 3), 64'hB0 + 64'(k)), $sformatf("bp_vc1_b%0d", k));
        end
        exp_a = pkt_flit(1'b0, 2'd2, 64'hA0);
        exp_b = pkt_flit(1'b1, 2'd1, 64'hB0);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            in_flit       = beat(1'(c % 2), 2'd0, 1'b0, 64'hFF);
            in_flit_valid = 1'b1;
            #1;
            chk($sformatf("bp%0d_in_rdy", c), OutW'(in_flit_ready), '0);
            chk($sformatf("bp%0d_out_valid", c), OutW'(out_flit_valid), OutW'(1));
            chk($sformatf("bp%0d_out_flit", c), out_flit, exp_a);
        end
        @(negedge CLK);
        in_flit_valid  = 1'b0;
        out_flit_ready = 1'b1;
        #1;
        chk("bp_rel0_flit", out_flit, exp_a);
        chk("bp_rel0_valid", OutW'(out_flit_valid), OutW'(1));
        @(negedge CLK);
        #1;
        chk("bp_rel1_flit", out_flit, exp_b);
        chk("bp_rel1_valid", OutW'(out_flit_valid), OutW'(1));
        @(negedge CLK);
        #1;
        chk("bp_rel2_valid", OutW'(out_flit_valid), '0);
        out_flit_ready = 1'b0;

        // Round-robin: both lanes full at every decision, grants must alternate.
        send_pkt(1'b0, 2'd1, 64'h100);
        send_pkt(1'b1, 2'd2, 64'h200);
        exp_rr[0] = pkt_flit(1'b0, 2'd1, 64'h100);
        exp_rr[1] = pkt_flit(1'b1, 2'd2, 64'h200);
        for (int r = 0; r < 4; r++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("rr%0d_valid", r), OutW'(out_flit_valid), OutW'(1));
            chk($sformatf("rr%0d_flit", r), out_flit, exp_rr[r % 2]);
            out_flit_ready = 1'b1;
            @(posedge CLK);
            #1;
            out_flit_ready = 1'b0;
            send_pkt(1'(r % 2), 2'(r), 64'h300 + 64'(r * 16));
            exp_rr[r % 2] = pkt_flit(1'(r % 2), 2'(r), 64'h300 + 64'(r * 16));
        end
        @(negedge CLK);
        out_flit_ready = 1'b1;
        #1;
        chk("rr_drain0_flit", out_flit, exp_rr[0]);
        @(negedge CLK);
        #1;
        chk("rr_drain1_flit", out_flit, exp_rr[1]);
        @(negedge CLK);
        #1;
        chk("rr_drain_idle", OutW'(out_flit_valid), '0);

        // Reset mid-packet discards the partial VC1 packet.
        send_beat(beat(1'b1, 2'd0, 1'b0, 64'hDEAD0), "mr_old_b0");
        send_beat(beat(1'b1, 2'd0, 1'b0, 64'hDEAD1), "mr_old_b1");
        @(negedge CLK);
        RST_N         = 1'b0;
        in_flit       = beat(1'b1, 2'd0, 1'b0, 64'h0);
        in_flit_valid = 1'b1;
        #1;
        chk("mr_in_rdy", OutW'(in_flit_ready), '0);
        chk("mr_out_valid", OutW'(out_flit_valid), '0);
        chk("mr_out_flit", out_flit, '0);
        @(negedge CLK);
        RST_N         = 1'b1;
        in_flit_valid = 1'b0;
        send_pkt(1'b1, 2'd3, 64'h500);
        @(negedge CLK);
        #1;
        chk("mr_new_valid", OutW'(out_flit_valid), OutW'(1));
        chk("mr_new_flit", out_flit, pkt_flit(1'b1, 2'd3, 64'h500));
        @(negedge CLK);
        #1;
        chk("mr_single_flit", OutW'(out_flit_valid), '0);

`ifdef FLIT_VC_DESER_ERRCHK_EN
        chk("err_init", OutW'(err), '0);
        send_beat(beat(1'b0, 2'd1, 1'b0, 64'h1), "err_b0");
        send_beat(beat(1'b0, 2'd1, 1'b0, 64'h2), "err_b1");
        chk("err_after_b2", OutW'(err), '0);
        send_beat(beat(1'b0, 2'd3, 1'b0, 64'h3), "err_b2");
        chk("err_after_b3", OutW'(err), OutW'(1));
        send_beat(beat(1'b0, 2'd1, 1'b1, 64'h4), "err_b3");
        chk("err_after_b4", OutW'(err), OutW'(1));
        @(negedge CLK);
        #1;
        chk("err_pkt_flit", out_flit, ofl(1'b0, 2'd1, 1'b1, 64'h1, 64'h2, 64'h3, 64'h4));
        repeat (3) @(negedge CLK);
        #1;
        chk("err_sticky", OutW'(err), OutW'(1));
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("err_cleared", OutW'(err), '0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
